bottle_fill_ctrl: RTL and testbench
===================================

// Module: bottle_fill_ctrl
// PURPOSE
//  Parametrised multi-lane pill-bottling controller; successor to the single-lane set/count/allFull path.
//  Holds two BCD targets: pills per bottle and bottles per batch. Counts pills on LANES parallel chutes
//  and counts completed bottles on one shared counter. Raises all_full / done_pulse for the display and Music blocks.
//  Adds pause/resume, config validation, and arbitration when lanes complete in the same cycle.
// PARAMETERS
//  DIGITS  2  BCD digits per count/target (field width 4*DIGITS)
//  LANES   2  number of parallel filling lanes (1..8)
// PORTS
//  CLK          in   1             system clock, all state on rising edge
//  RST          in   1             asynchronous, active-high reset
//  cfg_we       in   1             write cfg_val into the target chosen by cfg_sel
//  cfg_sel      in   1             0 = pills-per-bottle target, 1 = bottles-per-batch target
//  cfg_val      in   4*DIGITS      packed BCD value, MS digit in the top nibble
//  start        in   1             begin (or restart) a batch
//  hold         in   1             level; pause filling while high
//  clear        in   1             abort batch, zero counters, keep targets
//  pill_in      in   LANES         one-cycle pill pulse per lane
//  lane_ready   out  LANES         lane gate open (pills on this lane are accepted)
//  lane_cnt     out  LANES*4*DIGITS  per-lane BCD pill count, lane 0 in the LSBs
//  seq_cnt      out  4*DIGITS      BCD count of completed bottles
//  bottle_done  out  LANES         one-cycle pulse per completed bottle
//  all_full     out  1             level; batch complete
//  done_pulse   out  1             one cycle on entry to DONE (Music trigger)
//  busy         out  1             state is RUN or PAUSE
//  cfg_err      out  1             last cfg write rejected, or start issued with a zero target
// BEHAVIOUR
//  - Reset: every output 0, targets 0, state IDLE.
//  - States: IDLE, RUN, PAUSE, DONE.
//      IDLE  --start & both targets != 0-->  RUN (counters zeroed).
//      IDLE  --start & either target == 0--> stay IDLE, cfg_err = 1.
//      RUN   --hold--> PAUSE;  PAUSE --!hold--> RUN.
//      RUN   --seq_cnt reaches bottle target--> DONE.
//      DONE  --start--> RUN (counters zeroed).
//      any   --clear--> IDLE. clear has priority over start; start has priority over hold.
//  - Config:
//      Writes are accepted only in IDLE or DONE; ignored (cfg_err unchanged) in RUN/PAUSE.
//      A write with any nibble > 9 is rejected: target unchanged, cfg_err = 1.
//      A valid write or a valid start clears cfg_err.
//  - lane_ready[i] = (state == RUN) & lane i not stalled. A pill while !lane_ready[i] is dropped.
//  - Accepted pill: lane_cnt[i] BCD-increments, visible on the next cycle.
//      Each digit wraps 9->0 with carry into the next digit.
//  - Completion: a pill that would make lane_cnt[i] == pill target completes a bottle.
//      Next cycle: lane_cnt[i] = 0, bottle_done[i] = 1, seq_cnt += number of completions accepted.
//      Total latency pill -> bottle_done = 1 cycle.
//  - Simultaneous completions:
//      Let R = remaining bottles (bottle target - seq_cnt). Accept the lowest-index completions, up to R.
//      A rejected lane holds lane_cnt = target, lane_ready = 0, and gets no bottle_done.
//      Once seq_cnt == target the state goes to DONE.
//      Stalled lanes clear on start or clear.
//  - DONE: all_full = 1, done_pulse = 1 for exactly the entry cycle, all lane_ready = 0, counts held.
//  - Counters never exceed their targets.
//      Pill target 1 makes every accepted pill complete a bottle; lane_cnt stays 0.
//  - Reset mid-operation: immediate asynchronous return to the reset values above.
// STRUCTURE
//  - Shared package bottle_pkg: state enum {IDLE, RUN, PAUSE, DONE}, CFG_SEL_PILL = 0, CFG_SEL_BOT = 1,
//    BCD digit width 4, helper function bcd_valid().
//  - Sub-module bcd_counter #(DIGITS): clr, inc, q, nxt (q+1 in BCD).
//    Instantiated LANES times for lane counts, once for seq_cnt.
//    seq_cnt steps by up to LANES per cycle through a chained nxt compute.
//  - Top level holds the FSM, config registers, and the completion arbiter (priority mask by lane index).
// TESTING
//  1 Reset: assert RST mid-RUN with counts nonzero -> all outputs 0 immediately, state IDLE, targets 0.
//  2 LANES=1: pill target 0x03, bottle target 0x02, start, 6 pills on lane 0
//    -> bottle_done after pills 3 and 6; seq_cnt 0x01 then 0x02; all_full = 1; done_pulse high one cycle; lane_ready = 0.
//  3 BCD carry: pill target 0x12, 10 pills -> lane_cnt 0x10; 2 more -> bottle_done, lane_cnt 0x00.
//  4 LANES=2: bottle target 0x03, seq_cnt 0x02, both lanes complete in one cycle
//    -> bottle_done = 2'b01, seq_cnt 0x03, lane 1 holds at target with lane_ready[1] = 0, all_full = 1.
//  5 Config: cfg_val 0x1A -> cfg_err = 1, target unchanged; valid write during RUN ignored;
//    start with pill target 0 -> stays IDLE, cfg_err = 1.
//  6 Pause: hold high after 2 pills; 3 pills during PAUSE -> dropped, lane_cnt stays 0x02, busy = 1;
//    hold low -> filling resumes; clear -> IDLE, counts 0, targets kept.

Source files
------------

// File: rtl/bottle_pkg.sv
`default_nettype none
// ============================================================================
// Package : bottle_pkg
// Brief   : Shared types, constants and BCD helpers for the bottle filler.
// Rev     : 1.0  initial release
// ============================================================================
package bottle_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic CFG_SEL_PILL = 1'b0;
  localparam logic CFG_SEL_BOT  = 1'b1;
  localparam int   BCD_W        = 4;

  // True when a single nibble is a legal BCD digit
  function automatic logic bcd_valid(input logic [BCD_W-1:0] d);
    return (d <= 4'd9);
  endfunction

  // One BCD digit step with carry: returns {carry_out, digit_out}
  function automatic logic [BCD_W:0] bcd_step(input logic [BCD_W-1:0] d, input logic cin);
    logic [BCD_W:0] r;
    r = {1'b0, d};
    if (cin) begin
      if (d == 4'd9) r = {1'b1, 4'd0};
      else           r = {1'b0, d + 4'd1};
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bottle_fill_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface : bottle_if
// Brief     : Control, config, pill and status bundle of bottle_fill_ctrl.
// Rev       : 1.0  initial release
// ============================================================================
interface bottle_if #(
  parameter int DIGITS = 2,
  parameter int LANES  = 2
);
  logic                        cfg_we;
  logic                        cfg_sel;
  logic [4*DIGITS-1:0]         cfg_val;
  logic                        start;
  logic                        hold;
  logic                        clear;
  logic [LANES-1:0]            pill_in;
  logic [LANES-1:0]            lane_ready;
  logic [LANES*4*DIGITS-1:0]   lane_cnt;
  logic [4*DIGITS-1:0]         seq_cnt;
  logic [LANES-1:0]            bottle_done;
  logic                        all_full;
  logic                        done_pulse;
  logic                        busy;
  logic                        cfg_err;

  modport master (
    output cfg_we, cfg_sel, cfg_val, start, hold, clear, pill_in,
    input  lane_ready, lane_cnt, seq_cnt, bottle_done, all_full, done_pulse, busy, cfg_err
  );

  modport slave (
    input  cfg_we, cfg_sel, cfg_val, start, hold, clear, pill_in,
    output lane_ready, lane_cnt, seq_cnt, bottle_done, all_full, done_pulse, busy, cfg_err
  );
endinterface
`default_nettype wire

// File: rtl/bottle_fill_ctrl_bcd_counter.sv
`default_nettype none
// ============================================================================
// Module : bcd_counter
// Brief  : DIGITS-wide BCD register with clear, load and +1; also exposes
//          the +1 value combinationally so callers can test completion.
// Rev    : 1.0  initial release
// ============================================================================
module bcd_counter
  import bottle_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  i_clr,
  input  wire logic                  i_inc,
  input  wire logic                  i_ld,
  input  wire logic [BCD_W*DIGITS-1:0] i_d,
  output logic      [BCD_W*DIGITS-1:0] o_q,
  output logic      [BCD_W*DIGITS-1:0] o_nxt
);
  localparam int W = BCD_W * DIGITS;

  logic [W-1:0] r_q;
  logic [W-1:0] w_nxt;
  logic         w_carry;
  logic [BCD_W:0] w_step;

  // Ripple a +1 through the digits, least significant first
  always_comb begin
    w_nxt   = r_q;
    w_carry = 1'b1;
    w_step  = '0;
    for (int d = 0; d < DIGITS; d++) begin
      w_step                 = bcd_step(r_q[d*BCD_W +: BCD_W], w_carry);
      w_nxt[d*BCD_W +: BCD_W] = w_step[BCD_W-1:0];
      w_carry                = w_step[BCD_W];
    end
  end

  // Count register: clear beats load beats increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_q <= '0;
    else if (i_clr) r_q <= '0;
    else if (i_ld)  r_q <= i_d;
    else if (i_inc) r_q <= w_nxt;
  end

  assign o_q   = r_q;
  assign o_nxt = w_nxt;
endmodule
`default_nettype wire

// File: rtl/bottle_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module : bottle_fill_ctrl
// Brief  : Multi-lane pill-bottling controller: BCD targets, per-lane pill
//          counters, shared bottle counter, completion arbiter and FSM.
// Rev    : 1.0  initial release
// ============================================================================
module bottle_fill_ctrl
  import bottle_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int LANES  = 2
) (
  input  wire logic CLK,
  input  wire logic RST,
  bottle_if.slave   bus
);
  localparam int W = BCD_W * DIGITS;

  state_t           r_state, w_state_nxt;
  logic [W-1:0]     r_tgt_pill, r_tgt_bot;
  logic             r_cfg_err;
  logic [LANES-1:0] r_stall, r_bottle_done;
  logic             r_done_pulse;

  logic [LANES-1:0] w_lane_ready, w_acc, w_comp, w_grant;
  logic [W-1:0]     w_lane_q   [LANES];
  logic [W-1:0]     w_lane_nxt [LANES];
  logic [W-1:0]     w_seq_q, w_seq_chain;
  logic [BCD_W:0]   w_step;
  logic             w_carry, w_cfg_ok, w_tgt_ok, w_start_ok, w_zero, w_cfg_open, w_finish;

  assign w_tgt_ok   = (r_tgt_pill != '0) && (r_tgt_bot != '0);
  assign w_start_ok = bus.start && !bus.clear && w_tgt_ok;
  assign w_zero     = bus.clear || w_start_ok;
  assign w_cfg_open = (r_state == IDLE) || (r_state == DONE);
  assign w_acc      = bus.pill_in & w_lane_ready;

  // Every nibble of an incoming config word must be a legal BCD digit
  always_comb begin
    w_cfg_ok = 1'b1;
    for (int d = 0; d < DIGITS; d++)
      if (!bcd_valid(bus.cfg_val[d*BCD_W +: BCD_W])) w_cfg_ok = 1'b0;
  end

  // Completion arbiter: lowest lane first, each grant steps the bottle count
  // once more; stop granting when the chained count hits the bottle target
  always_comb begin
    w_comp      = '0;
    w_grant     = '0;
    w_seq_chain = w_seq_q;
    w_carry     = 1'b0;
    w_step      = '0;
    for (int i = 0; i < LANES; i++) begin
      w_comp[i] = w_acc[i] && (w_lane_nxt[i] == r_tgt_pill);
      if (w_comp[i] && (w_seq_chain != r_tgt_bot)) begin
        w_grant[i] = 1'b1;
        w_carry    = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
          w_step                         = bcd_step(w_seq_chain[d*BCD_W +: BCD_W], w_carry);
          w_seq_chain[d*BCD_W +: BCD_W] = w_step[BCD_W-1:0];
          w_carry                        = w_step[BCD_W];
        end
      end
    end
    w_finish = (w_grant != '0) && (w_seq_chain == r_tgt_bot);
  end

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state: clear, then start, then finishing, then hold
  always_comb begin
    w_state_nxt = r_state;
    if (bus.clear)       w_state_nxt = IDLE;
    else if (bus.start) begin
      if (w_tgt_ok)      w_state_nxt = RUN;
    end else begin
      case (r_state)
        RUN:   if (w_finish) w_state_nxt = DONE;
               else if (bus.hold) w_state_nxt = PAUSE;
        PAUSE: if (!bus.hold) w_state_nxt = RUN;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // State-decoded outputs
  always_comb begin
    w_lane_ready = (r_state == RUN) ? ~r_stall : '0;
    bus.busy     = (r_state == RUN) || (r_state == PAUSE);
    bus.all_full = (r_state == DONE);
  end

  // Target registers and config error flag; a start decision overrides a write
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_tgt_pill <= '0;
      r_tgt_bot  <= '0;
      r_cfg_err  <= 1'b0;
    end else begin
      if (bus.cfg_we && w_cfg_open) begin
        if (w_cfg_ok) begin
          if (bus.cfg_sel == CFG_SEL_BOT) r_tgt_bot  <= bus.cfg_val;
          else                            r_tgt_pill <= bus.cfg_val;
          r_cfg_err <= 1'b0;
        end else begin
          r_cfg_err <= 1'b1;
        end
      end
      if (bus.start && !bus.clear) r_cfg_err <= !w_tgt_ok;
    end
  end

  // Lane stalls, bottle_done pulses and the DONE entry pulse
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_stall       <= '0;
      r_bottle_done <= '0;
      r_done_pulse  <= 1'b0;
    end else begin
      r_done_pulse <= (w_state_nxt == DONE) && (r_state != DONE);
      if (w_zero) begin
        r_stall       <= '0;
        r_bottle_done <= '0;
      end else begin
        r_stall       <= r_stall | (w_comp & ~w_grant);
        r_bottle_done <= w_grant;
      end
    end
  end

  // A rejected completion still increments, parking the lane at its target
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    bcd_counter #(.DIGITS(DIGITS)) u_lane (
      .clk   (CLK),
      .rst   (RST),
      .i_clr (w_zero || w_grant[i]),
      .i_inc (w_acc[i] && !w_grant[i]),
      .i_ld  (1'b0),
      .i_d   ('0),
      .o_q   (w_lane_q[i]),
      .o_nxt (w_lane_nxt[i])
    );
    assign bus.lane_cnt[i*W +: W] = w_lane_q[i];
  end

  bcd_counter #(.DIGITS(DIGITS)) u_seq (
    .clk   (CLK),
    .rst   (RST),
    .i_clr (w_zero),
    .i_inc (1'b0),
    .i_ld  (w_grant != '0),
    .i_d   (w_seq_chain),
    .o_q   (w_seq_q),
    .o_nxt ()
  );

  assign bus.seq_cnt     = w_seq_q;
  assign bus.lane_ready  = w_lane_ready;
  assign bus.bottle_done = r_bottle_done;
  assign bus.done_pulse  = r_done_pulse;
  assign bus.cfg_err     = r_cfg_err;
endmodule
`default_nettype wire

// File: tb/tb_bottle_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_bottle_fill_ctrl
// Brief  : Directed bench with a bottle_done scoreboard for bottle_fill_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
module tb_bottle_fill_ctrl;
  localparam int DIGITS = 2;
  localparam int LANES  = 2;

  typedef struct packed {
    logic [1:0]  bd;
    logic [7:0]  seq;
    logic [15:0] lanes;
    logic        full;
    logic        dp;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  bottle_if #(.DIGITS(DIGITS), .LANES(LANES)) bus ();

  bottle_fill_ctrl #(.DIGITS(DIGITS), .LANES(LANES)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Scoreboard monitor: every bottle_done pulse consumes one expectation
  always @(negedge CLK) begin
    if (!RST && bus.bottle_done != '0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_bottle_done got %b expected none", bus.bottle_done);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_bottle_done", 32'(bus.bottle_done), 32'(e.bd));
        check("sb_seq_cnt",     32'(bus.seq_cnt),     32'(e.seq));
        check("sb_lane_cnt",    32'(bus.lane_cnt),    32'(e.lanes));
        check("sb_all_full",    32'(bus.all_full),    32'(e.full));
        check("sb_done_pulse",  32'(bus.done_pulse),  32'(e.dp));
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic cfg(input logic sel, input logic [7:0] val);
    bus.cfg_we = 1'b1; bus.cfg_sel = sel; bus.cfg_val = val;
    tick();
    bus.cfg_we = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1; tick(); bus.clear = 1'b0;
  endtask

  task automatic pill(input logic [1:0] m);
    bus.pill_in = m; tick(); bus.pill_in = '0;
  endtask

  task automatic pill_exp(input logic [1:0] m, input logic [1:0] bd, input logic [7:0] seq,
                          input logic [15:0] lanes, input logic full, input logic dp);
    exp_t e;
    e = '{bd: bd, seq: seq, lanes: lanes, full: full, dp: dp};
    exp_q.push_back(e);
    pill(m);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_lane_cnt"},    32'(bus.lane_cnt),    32'h0);
    check({tag, "_seq_cnt"},     32'(bus.seq_cnt),     32'h0);
    check({tag, "_busy"},        32'(bus.busy),        32'h0);
    check({tag, "_all_full"},    32'(bus.all_full),    32'h0);
    check({tag, "_done_pulse"},  32'(bus.done_pulse),  32'h0);
    check({tag, "_lane_ready"},  32'(bus.lane_ready),  32'h0);
    check({tag, "_bottle_done"}, 32'(bus.bottle_done), 32'h0);
    check({tag, "_cfg_err"},     32'(bus.cfg_err),     32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.cfg_we = 1'b0; bus.cfg_sel = 1'b0; bus.cfg_val = '0;
    bus.start = 1'b0; bus.hold = 1'b0; bus.clear = 1'b0; bus.pill_in = '0;
    tick(); tick();
    check_zero("rst");
    RST = 1'b0;
    tick();

    // Config validation
    cfg(1'b0, 8'h1A);
    check("bad_cfg_err", 32'(bus.cfg_err), 32'h1);
    cfg(1'b1, 8'h02);
    check("good_cfg_err", 32'(bus.cfg_err), 32'h0);
    pulse_start();
    check("zero_tgt_busy", 32'(bus.busy), 32'h0);
    check("zero_tgt_err",  32'(bus.cfg_err), 32'h1);

    // Single lane batch: 3 pills/bottle, 2 bottles
    cfg(1'b0, 8'h03);
    check("cfg3_err", 32'(bus.cfg_err), 32'h0);
    pulse_start();
    check("run_busy",  32'(bus.busy), 32'h1);
    check("run_ready", 32'(bus.lane_ready), 32'h3);
    pill(2'b01);
    check("l0_cnt1", 32'(bus.lane_cnt), 32'h0001);
    pill(2'b01);
    check("l0_cnt2", 32'(bus.lane_cnt), 32'h0002);
    pill_exp(2'b01, 2'b01, 8'h01, 16'h0000, 1'b0, 1'b0);
    pill(2'b01);
    pill(2'b01);
    pill_exp(2'b01, 2'b01, 8'h02, 16'h0000, 1'b1, 1'b1);
    check("done_full",  32'(bus.all_full), 32'h1);
    check("done_ready", 32'(bus.lane_ready), 32'h0);
    check("done_busy",  32'(bus.busy), 32'h0);
    tick();
    check("done_pulse_once", 32'(bus.done_pulse), 32'h0);
    check("done_full_held",  32'(bus.all_full), 32'h1);
    pill(2'b01);
    check("done_pill_drop", 32'(bus.lane_cnt), 32'h0000);

    // BCD carry on lane 1: target 12
    cfg(1'b0, 8'h12);
    cfg(1'b1, 8'h05);
    pulse_start();
    for (int k = 0; k < 10; k++) pill(2'b10);
    check("carry_cnt10", 32'(bus.lane_cnt), 32'h1000);
    pill(2'b10);
    pill_exp(2'b10, 2'b10, 8'h01, 16'h0000, 1'b0, 1'b0);

    // Writes during RUN are ignored
    cfg(1'b0, 8'h03);
    cfg(1'b0, 8'h1A);
    check("run_write_err", 32'(bus.cfg_err), 32'h0);
    for (int k = 0; k < 3; k++) pill(2'b01);
    check("run_write_ignored", 32'(bus.lane_cnt), 32'h0003);

    // Clear and pause
    pulse_clear();
    check("clr_cnt",  32'(bus.lane_cnt), 32'h0);
    check("clr_seq",  32'(bus.seq_cnt), 32'h0);
    check("clr_busy", 32'(bus.busy), 32'h0);
    pulse_start();
    check("tgt_kept_busy", 32'(bus.busy), 32'h1);
    pill(2'b01); pill(2'b01);
    bus.hold = 1'b1;
    tick();
    check("pause_ready", 32'(bus.lane_ready), 32'h0);
    check("pause_busy",  32'(bus.busy), 32'h1);
    for (int k = 0; k < 3; k++) pill(2'b01);
    check("pause_drop", 32'(bus.lane_cnt), 32'h0002);
    bus.hold = 1'b0;
    tick();
    check("resume_ready", 32'(bus.lane_ready), 32'h3);
    pill(2'b01);
    check("resume_cnt", 32'(bus.lane_cnt), 32'h0003);
    pulse_clear();
    check("clr2_cnt",  32'(bus.lane_cnt), 32'h0);
    check("clr2_busy", 32'(bus.busy), 32'h0);

    // Simultaneous completions with one bottle remaining
    cfg(1'b0, 8'h02);
    cfg(1'b1, 8'h03);
    pulse_start();
    pill(2'b01);
    pill_exp(2'b01, 2'b01, 8'h01, 16'h0000, 1'b0, 1'b0);
    pill(2'b10);
    pill_exp(2'b10, 2'b10, 8'h02, 16'h0000, 1'b0, 1'b0);
    pill(2'b11);
    check("arb_pre", 32'(bus.lane_cnt), 32'h0101);
    pill_exp(2'b11, 2'b01, 8'h03, 16'h0200, 1'b1, 1'b1);
    check("arb_ready", 32'(bus.lane_ready), 32'h0);
    check("arb_full",  32'(bus.all_full), 32'h1);

    // Asynchronous reset mid-run
    pulse_start();
    check("restart_ready", 32'(bus.lane_ready), 32'h3);
    pill(2'b11);
    pill_exp(2'b01, 2'b01, 8'h01, 16'h0100, 1'b0, 1'b0);
    @(negedge CLK);
    #1;
    RST = 1'b1;
    #1;
    check_zero("arst");
    tick();
    RST = 1'b0;
    tick();
    pulse_start();
    check("arst_tgt_busy", 32'(bus.busy), 32'h0);
    check("arst_tgt_err",  32'(bus.cfg_err), 32'h1);

    repeat (3) tick();
    check("sb_queue_empty", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
